// File: rtl/ex_mem_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage_reg
//  Description : EX->MEM pipeline register with valid/ready flow control,
//                optional 2-entry skid buffer, flush and bubble squashing.
//                Optional perf counters when EX_MEM_PERF_EN is defined.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CTRL_W     = 3,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic [REG_ADDR_W-1:0] in_rd_num,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd_num
`ifdef EX_MEM_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    localparam int ENT_W = CTRL_W + 2 * DATA_W + REG_ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q;
    logic [ENT_W-1:0]   main_q;
    logic [ENT_W-1:0]   skid_q;
    logic [CTRL_W-1:0]  in_ctrl_sq;
    logic [ENT_W-1:0]   in_ent;
    logic               in_xfer;
    logic               out_xfer;

    // A write to r0 is architecturally a no-op, so drop reg_write at capture.
    always_comb begin
        in_ctrl_sq    = in_ctrl;
        in_ctrl_sq[0] = in_ctrl[0] & (|in_rd_num);
    end

    assign in_ent   = {in_ctrl_sq, in_alu_result, in_store_data, in_rd_num};
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    assign out_valid      = (state_q != ST_EMPTY);
    assign out_ctrl       = out_valid ? main_q[ENT_W-1 -: CTRL_W] : '0;
    assign out_alu_result = main_q[ENT_W-CTRL_W-1 -: DATA_W];
    assign out_store_data = main_q[REG_ADDR_W+DATA_W-1 -: DATA_W];
    assign out_rd_num     = main_q[REG_ADDR_W-1:0];

    generate
        if (SKID != 0) begin : g_skid
            // Decoded from the state flop only: no path from out_ready.
            assign in_ready = !rst && (state_q != ST_SKID);
        end else begin : g_single
            assign in_ready = !rst && (!out_valid || out_ready);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_q  <= in_ent;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_q <= in_ent;
                    end else if (out_xfer) begin
                        state_q <= ST_EMPTY;
                    end else if (in_xfer) begin
                        skid_q  <= in_ent;
                        state_q <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (out_xfer) begin
                        main_q  <= skid_q;
                        state_q <= ST_FULL;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

`ifdef EX_MEM_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush && out_valid && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage_reg
//  Description : Self-checking bench for ex_mem_stage_reg, SKID=1 and SKID=0
//                instances sharing one stimulus stream, queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage_reg;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_ctrl = '0;
    logic [31:0] in_alu = '0;
    logic [31:0] in_sd = '0;
    logic [4:0]  in_rd = '0;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [2:0]  a_out_ctrl, b_out_ctrl;
    logic [31:0] a_out_alu, a_out_sd, b_out_alu, b_out_sd;
    logic [4:0]  a_out_rd, b_out_rd;
`ifdef EX_MEM_PERF_EN
    logic [31:0] a_stall, b_stall;
    logic [15:0] a_fl, b_fl;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ent_t qa[$];
    ent_t qb[$];
    ent_t last_a = '0;
    ent_t last_b = '0;
    ent_t e_in;
    logic pa, pb;

    always #5 clk = ~clk;

    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(3), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl),
        .in_alu_result(in_alu), .in_store_data(in_sd), .in_rd_num(in_rd),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_alu_result(a_out_alu), .out_store_data(a_out_sd), .out_rd_num(a_out_rd)
`ifdef EX_MEM_PERF_EN
        , .stall_cnt(a_stall), .flush_cnt(a_fl)
`endif
    );

    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .CTRL_W(3), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl),
        .in_alu_result(in_alu), .in_store_data(in_sd), .in_rd_num(in_rd),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_alu_result(b_out_alu), .out_store_data(b_out_sd), .out_rd_num(b_out_rd)
`ifdef EX_MEM_PERF_EN
        , .stall_cnt(b_stall), .flush_cnt(b_fl)
`endif
    );

    // Reference: each stage is a FIFO of capacity 2 (SKID=1) or 1 (SKID=0).
    always @(posedge clk) begin
        e_in.ctrl = {in_ctrl[2:1], in_ctrl[0] & (in_rd != 5'd0)};
        e_in.alu  = in_alu;
        e_in.sd   = in_sd;
        e_in.rd   = in_rd;
        if (rst) begin
            qa.delete(); qb.delete();
            last_a = '0; last_b = '0;
        end else if (flush) begin
            qa.delete(); qb.delete();
        end else begin
            pa = in_valid && (qa.size() < 2);
            pb = in_valid && ((qb.size() == 0) || out_ready);
            if (qa.size() != 0 && out_ready) void'(qa.pop_front());
            if (qb.size() != 0 && out_ready) void'(qb.pop_front());
            if (pa) qa.push_back(e_in);
            if (pb) qb.push_back(e_in);
            if (qa.size() != 0) last_a = qa[0];
            if (qb.size() != 0) last_b = qb[0];
        end
    end

    task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] alu,
                         input logic [4:0] rd, input logic ordy, input logic fl);
        in_valid = v; in_ctrl = c; in_alu = alu; in_sd = ~alu; in_rd = rd;
        out_ready = ordy; flush = fl;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 3'b111, 32'hDEAD, 5'd1, 1'b0, 1'b0);
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({a_in_ready, a_out_valid, a_out_ctrl, b_in_ready, b_out_valid} !== 7'b0 ||
                a_out_alu !== 32'h0 || a_out_rd !== 5'h0) begin
                n_err++;
                $display("FAIL reset_state: got a_rdy=%b a_vld=%b a_ctrl=%b b_rdy=%b b_vld=%b alu=%h rd=%h, want all 0",
                         a_in_ready, a_out_valid, a_out_ctrl, b_in_ready, b_out_valid, a_out_alu, a_out_rd);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got a_rdy=%b b_rdy=%b a_vld=%b, want 1 1 0",
                     a_in_ready, b_in_ready, a_out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_stream;
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, 3'b001, vals[i], 5'd3, 1'b1, 1'b0);
            else       drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
            #1;
            if (i == 0) begin
                n_cmp++;
                if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL stream_start: got rdy=%b vld=%b, want 1 0", a_in_ready, a_out_valid);
                end
            end else if (i < 4) begin
                n_cmp++;
                if (a_out_valid !== 1'b1 || a_out_alu !== vals[i-1] || a_out_ctrl !== 3'b001 ||
                    b_out_valid !== 1'b1 || b_out_alu !== vals[i-1]) begin
                    n_err++;
                    $display("FAIL stream_out%0d: got a=%b/%h/%b b=%b/%h, want 1/%h/001",
                             i, a_out_valid, a_out_alu, a_out_ctrl, b_out_valid, b_out_alu, vals[i-1]);
                end
            end else begin
                n_cmp++;
                if (a_out_valid !== 1'b0 || a_out_ctrl !== 3'b000 || a_out_alu !== 32'h33 ||
                    a_out_sd !== ~32'h33) begin
                    n_err++;
                    $display("FAIL stream_hold: got vld=%b ctrl=%b alu=%h sd=%h, want 0 000 00000033 ffffffcc",
                             a_out_valid, a_out_ctrl, a_out_alu, a_out_sd);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_skid;
        drive(1'b1, 3'b011, 32'hA0, 5'd4, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin
            n_err++; $display("FAIL skid_accA: got rdy=%b want 1", a_in_ready);
        end
        @(negedge clk);
        drive(1'b1, 3'b101, 32'hB0, 5'd6, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_out_alu !== 32'hA0 || a_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL skid_accB: got a_rdy=%b alu=%h vld=%b b_rdy=%b, want 1 a0 1 0",
                     a_in_ready, a_out_alu, a_out_valid, b_in_ready);
        end
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) out_ready = 1'b1;
            #1;
            n_cmp++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_alu !== 32'hA0 ||
                a_out_ctrl !== 3'b011 || a_out_rd !== 5'd4) begin
                n_err++;
                $display("FAIL skid_full%0d: got rdy=%b vld=%b alu=%h ctrl=%b rd=%0d, want 0 1 a0 011 4",
                         i, a_in_ready, a_out_valid, a_out_alu, a_out_ctrl, a_out_rd);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_alu !== 32'hB0 || a_out_ctrl !== 3'b101 ||
            a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL skid_drainB: got vld=%b alu=%h ctrl=%b rdy=%b b_vld=%b, want 1 b0 101 1 0",
                     a_out_valid, a_out_alu, a_out_ctrl, a_in_ready, b_out_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0) begin
            n_err++; $display("FAIL skid_empty: got vld=%b want 0", a_out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        drive(1'b1, 3'b001, 32'hD0, 5'd2, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b001, 32'hE0, 5'd2, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 3'b111, 32'hF0, 5'd2, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_out_ctrl !== 3'b000 || a_in_ready !== 1'b1 ||
            a_out_alu !== 32'hD0 || b_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_full: got vld=%b ctrl=%b rdy=%b alu=%h b_vld=%b, want 0 000 1 d0 0",
                     a_out_valid, a_out_ctrl, a_in_ready, a_out_alu, b_out_valid);
        end
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h77, 5'd2, 1'b1, 1'b1);
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_rdy: got a_rdy=%b b_rdy=%b, want 1 1", a_in_ready, b_in_ready);
        end
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_out_alu !== 32'hD0) begin
            n_err++;
            $display("FAIL flush_drop_in: got a_vld=%b b_vld=%b alu=%h, want 0 0 d0",
                     a_out_valid, b_out_valid, a_out_alu);
        end
        @(negedge clk);
    endtask

    task automatic test_x0_squash;
        logic [2:0] want [3];
        want[0] = 3'b000; want[1] = 3'b110; want[2] = 3'b001;
        drive(1'b1, 3'b001, 32'h55, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i == 0)      drive(1'b1, 3'b111, 32'h66, 5'd0, 1'b1, 1'b0);
            else if (i == 1) drive(1'b1, 3'b001, 32'h67, 5'd9, 1'b1, 1'b0);
            else             drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_out_ctrl !== want[i] || b_out_ctrl !== want[i]) begin
                n_err++;
                $display("FAIL x0_squash%0d: got vld=%b a_ctrl=%b b_ctrl=%b, want 1 %b",
                         i, a_out_valid, a_out_ctrl, b_out_ctrl, want[i]);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

`ifdef EX_MEM_PERF_EN
    task automatic test_perf;
        rst = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_stall !== 32'd0 || a_fl !== 16'd0) begin
            n_err++; $display("FAIL perf_reset: got stall=%0d flush=%0d, want 0 0", a_stall, a_fl);
        end
        drive(1'b1, 3'b001, 32'h1, 5'd1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if (a_stall !== 32'd5 || a_fl !== 16'd1 || b_stall !== 32'd5 || b_fl !== 16'd1) begin
            n_err++;
            $display("FAIL perf_counts: got a=%0d/%0d b=%0d/%0d, want 5/1",
                     a_stall, a_fl, b_stall, b_fl);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_random(input int n);
        ent_t ea, eb;
        logic ra, rb, va, vb;
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_ctrl   = 3'($urandom);
            in_alu    = $urandom;
            in_sd     = $urandom;
            in_rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            #1;
            ra = (qa.size() < 2);
            rb = (qb.size() == 0) || out_ready;
            va = (qa.size() != 0);
            vb = (qb.size() != 0);
            if (va) ea = qa[0]; else begin ea = last_a; ea.ctrl = 3'd0; end
            if (vb) eb = qb[0]; else begin eb = last_b; eb.ctrl = 3'd0; end
            n_cmp++;
            if ({a_in_ready, a_out_valid, a_out_ctrl, a_out_alu, a_out_sd, a_out_rd} !== {ra, va, ea}) begin
                n_err++;
                $display("FAIL random_skid1 cyc%0d: got rdy=%b vld=%b ctrl=%b alu=%h sd=%h rd=%0d, want rdy=%b vld=%b ctrl=%b alu=%h sd=%h rd=%0d",
                         i, a_in_ready, a_out_valid, a_out_ctrl, a_out_alu, a_out_sd, a_out_rd,
                         ra, va, ea.ctrl, ea.alu, ea.sd, ea.rd);
            end
            n_cmp++;
            if ({b_in_ready, b_out_valid, b_out_ctrl, b_out_alu, b_out_sd, b_out_rd} !== {rb, vb, eb}) begin
                n_err++;
                $display("FAIL random_skid0 cyc%0d: got rdy=%b vld=%b ctrl=%b alu=%h sd=%h rd=%0d, want rdy=%b vld=%b ctrl=%b alu=%h sd=%h rd=%0d",
                         i, b_in_ready, b_out_valid, b_out_ctrl, b_out_alu, b_out_sd, b_out_rd,
                         rb, vb, eb.ctrl, eb.alu, eb.sd, eb.rd);
            end
            @(negedge clk);
        end
        drive(1'b0, 3'b000, 32'h0, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8 && (a_out_valid || b_out_valid); i++) @(negedge clk);
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got a_vld=%b b_vld=%b, want 0 0", a_out_valid, b_out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_x0_squash();
`ifdef EX_MEM_PERF_EN
        test_perf();
`endif
        test_random(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
